// File: rtl/counter_if.sv
// Register-style bus of counter_mod: clear/enable/load/direction/compare controls
// in, count value and status flags out.
interface counter_if #(
   parameter int WIDTH = 8
);
   logic             clr_i;
   logic             en_i;
   logic             we_i;
   logic [WIDTH-1:0] dat_i;
   logic             up_i;
   logic [WIDTH-1:0] cmp_i;
   logic             ovf_clr_i;
   logic [WIDTH-1:0] dat_o;
   logic             tc_o;
   logic             ovf_o;
   logic             match_o;

   modport master (
      output clr_i, en_i, we_i, dat_i, up_i, cmp_i, ovf_clr_i,
      input  dat_o, tc_o, ovf_o, match_o
   );

   modport slave (
      input  clr_i, en_i, we_i, dat_i, up_i, cmp_i, ovf_clr_i,
      output dat_o, tc_o, ovf_o, match_o
   );
endinterface

// File: rtl/counter_mod.sv
// Modulo-(MAX+1) up/down counter with synchronous clear, clamped parallel load,
// enable prescaler, terminal-count pulse, sticky overflow flag and compare match.
module counter_mod #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
   parameter int               PRESCALE = 1
) (
   input  logic     clk_i,
   input  logic     rst_i,
   counter_if.slave bus
);

   // The prescaler counts enabled cycles 0..PRESCALE-1; 8 bits cover PRESCALE up to 256.
   localparam logic [7:0]       PS_LAST = 8'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

   logic [WIDTH-1:0] cnt_r;
   logic [7:0]       presc_r;
   logic             tc_r;
   logic             ovf_r;

   logic [WIDTH-1:0] load_val_s;
   logic [WIDTH-1:0] step_val_s;
   logic             wrap_s;
   logic             ps_done_s;
   logic             step_s;
   logic             wrap_evt_s;

   // Clamped load value and the value/wrap outcome of one step in the sampled direction.
   always_comb begin
      load_val_s = bus.dat_i;
      step_val_s = cnt_r;
      wrap_s     = 1'b0;
      if (bus.dat_i > MAX) begin
         load_val_s = MAX;
      end else begin
         load_val_s = bus.dat_i;
      end
      if (bus.up_i) begin
         if (cnt_r == MAX) begin
            step_val_s = ZERO_W;
            wrap_s     = 1'b1;
         end else begin
            step_val_s = cnt_r + ONE_W;
            wrap_s     = 1'b0;
         end
      end else begin
         if (cnt_r == ZERO_W) begin
            step_val_s = MAX;
            wrap_s     = 1'b1;
         end else begin
            step_val_s = cnt_r - ONE_W;
            wrap_s     = 1'b0;
         end
      end
   end

   assign ps_done_s  = (presc_r == PS_LAST);
   assign step_s     = !bus.clr_i && !bus.we_i && bus.en_i && ps_done_s;
   assign wrap_evt_s = step_s && wrap_s;

   // Count, prescaler and terminal-count pulse; clear beats load beats counting.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_r   <= ZERO_W;
         presc_r <= 8'd0;
         tc_r    <= 1'b0;
      end else if (bus.clr_i) begin
         cnt_r   <= ZERO_W;
         presc_r <= 8'd0;
         tc_r    <= 1'b0;
      end else if (bus.we_i) begin
         cnt_r   <= load_val_s;
         presc_r <= 8'd0;
         tc_r    <= 1'b0;
      end else if (bus.en_i) begin
         if (ps_done_s) begin
            presc_r <= 8'd0;
            cnt_r   <= step_val_s;
            tc_r    <= wrap_s;
         end else begin
            presc_r <= presc_r + 8'd1;
            tc_r    <= 1'b0;
         end
      end else begin
         tc_r <= 1'b0;
      end
   end

   // Sticky overflow: a wrap sets it and wins over a simultaneous clear request.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ovf_r <= 1'b0;
      end else if (wrap_evt_s) begin
         ovf_r <= 1'b1;
      end else if (bus.ovf_clr_i) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign bus.dat_o   = cnt_r;
   assign bus.tc_o    = tc_r;
   assign bus.ovf_o   = ovf_r;
   // The count never exceeds MAX, so a compare value above MAX can never match.
   assign bus.match_o = (cnt_r == bus.cmp_i);

endmodule

// File: tb/tb_counter_mod.sv
// Bench for counter_mod: three instances (MAX=9/PS=1, MAX=255/PS=3, 4-bit MAX=6/PS=2)
// checked every cycle against an arithmetic model plus directed literal expectations.
module tb_counter_mod;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   counter_if #(.WIDTH(8)) ifa ();
   counter_if #(.WIDTH(8)) ifb ();
   counter_if #(.WIDTH(4)) ifc ();

   counter_mod #(.WIDTH(8), .MAX(8'd9),   .PRESCALE(1)) dut_a (.clk_i(clk), .rst_i(rst_n), .bus(ifa));
   counter_mod #(.WIDTH(8), .MAX(8'd255), .PRESCALE(3)) dut_b (.clk_i(clk), .rst_i(rst_n), .bus(ifb));
   counter_mod #(.WIDTH(4), .MAX(4'd6),   .PRESCALE(2)) dut_c (.clk_i(clk), .rst_i(rst_n), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      int   cnt;
      int   ps;
      logic tc;
      logic ovf;
   } mstate_t;

   mstate_t ma, mb, mc;

   // Behavioural model: value space is 0..max, a step is +1 or -1 modulo (max+1),
   // the prescaler is the number of enabled cycles since the interval began.
   function automatic mstate_t model_next(input mstate_t s, input int max, input int psn,
                                          input logic clr, input logic en, input logic we,
                                          input logic up, input logic oc, input int din);
      mstate_t n;
      logic    wrap;
      n    = s;
      wrap = 1'b0;
      n.tc = 1'b0;
      if (clr) begin
         n.cnt = 0;
         n.ps  = 0;
      end else if (we) begin
         n.cnt = (din > max) ? max : din;
         n.ps  = 0;
      end else if (en) begin
         n.ps = (s.ps + 1) % psn;
         if (n.ps == 0) begin
            if (up) begin
               n.cnt = (s.cnt + 1) % (max + 1);
               wrap  = (n.cnt == 0);
            end else begin
               n.cnt = (s.cnt + max) % (max + 1);
               wrap  = (s.cnt == 0);
            end
            n.tc = wrap;
         end
      end
      n.ovf = wrap ? 1'b1 : (oc ? 1'b0 : s.ovf);
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model state advance, reset asynchronously like the design.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ma <= '0;
         mb <= '0;
         mc <= '0;
      end else begin
         ma <= model_next(ma, 9, 1, ifa.clr_i, ifa.en_i, ifa.we_i, ifa.up_i, ifa.ovf_clr_i, int'(ifa.dat_i));
         mb <= model_next(mb, 255, 3, ifb.clr_i, ifb.en_i, ifb.we_i, ifb.up_i, ifb.ovf_clr_i, int'(ifb.dat_i));
         mc <= model_next(mc, 6, 2, ifc.clr_i, ifc.en_i, ifc.we_i, ifc.up_i, ifc.ovf_clr_i, int'(ifc.dat_i));
      end
   end

   // Per-cycle comparison of all instances against the model on the falling edge.
   always @(negedge clk) begin
      chk("A.dat",   32'(ifa.dat_o),   32'(ma.cnt));
      chk("A.tc",    32'(ifa.tc_o),    32'(ma.tc));
      chk("A.ovf",   32'(ifa.ovf_o),   32'(ma.ovf));
      chk("A.match", 32'(ifa.match_o), 32'(ma.cnt == int'(ifa.cmp_i)));
      chk("B.dat",   32'(ifb.dat_o),   32'(mb.cnt));
      chk("B.tc",    32'(ifb.tc_o),    32'(mb.tc));
      chk("B.ovf",   32'(ifb.ovf_o),   32'(mb.ovf));
      chk("B.match", 32'(ifb.match_o), 32'(mb.cnt == int'(ifb.cmp_i)));
      chk("C.dat",   32'(ifc.dat_o),   32'(mc.cnt));
      chk("C.tc",    32'(ifc.tc_o),    32'(mc.tc));
      chk("C.ovf",   32'(ifc.ovf_o),   32'(mc.ovf));
      chk("C.match", 32'(ifc.match_o), 32'(mc.cnt == int'(ifc.cmp_i)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_a(input logic clr, input logic en, input logic we, input logic up,
                        input logic oc, input logic [7:0] d);
      ifa.clr_i     = clr;
      ifa.en_i      = en;
      ifa.we_i      = we;
      ifa.up_i      = up;
      ifa.ovf_clr_i = oc;
      ifa.dat_i     = d;
   endtask

   task automatic exp_a(input string nm, input int d, input logic tc, input logic ovf);
      chk({nm, ".dat"}, 32'(ifa.dat_o), 32'(d));
      chk({nm, ".tc"},  32'(ifa.tc_o),  32'(tc));
      chk({nm, ".ovf"}, 32'(ifa.ovf_o), 32'(ovf));
   endtask

   task automatic exp_c(input string nm, input int d, input logic tc, input logic ovf);
      chk({nm, ".dat"}, 32'(ifc.dat_o), 32'(d));
      chk({nm, ".tc"},  32'(ifc.tc_o),  32'(tc));
      chk({nm, ".ovf"}, 32'(ifc.ovf_o), 32'(ovf));
   endtask

   int seq1 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   int seq_dn [4] = '{1, 0, 9, 8};
   int seq_up [4] = '{6, 7, 8, 9};
   logic b_en [16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                       1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic b_we [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   int b_exp [16] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 50, 50, 50, 51};

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      drv_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      ifa.cmp_i     = 8'd0;
      ifb.clr_i     = 1'b0;
      ifb.en_i      = 1'b0;
      ifb.we_i      = 1'b0;
      ifb.up_i      = 1'b1;
      ifb.ovf_clr_i = 1'b0;
      ifb.dat_i     = 8'd0;
      ifb.cmp_i     = 8'd2;
      ifc.clr_i     = 1'b0;
      ifc.en_i      = 1'b0;
      ifc.we_i      = 1'b0;
      ifc.up_i      = 1'b0;
      ifc.ovf_clr_i = 1'b0;
      ifc.dat_i     = 4'd0;
      ifc.cmp_i     = 4'd6;
      repeat (2) tick();

      // Reset release and up count through the MAX=9 wrap.
      drv_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      rst_n = 1'b1;
      exp_a("rst", 0, 1'b0, 1'b0);
      for (int i = 1; i < 12; i++) begin
         tick();
         exp_a("up_seq", seq1[i], (i == 10), (i >= 10));
      end

      // Down wrap from a load of 2, then clamped load.
      drv_a(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2);
      tick();
      exp_a("load2", 2, 1'b0, 1'b1);
      drv_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_a("down_seq", seq_dn[i], (i == 2), 1'b1);
      end
      drv_a(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd200);
      tick();
      exp_a("clamp", 9, 1'b0, 1'b1);

      // Priority: clear over load over count, then overflow set/clear interplay.
      drv_a(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5);
      tick();
      exp_a("clr_pri", 0, 1'b0, 1'b1);
      drv_a(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5);
      tick();
      exp_a("we_pri", 5, 1'b0, 1'b1);
      drv_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_a("up_to9", seq_up[i], 1'b0, 1'b1);
      end
      drv_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0);
      tick();
      exp_a("wrap_ovfclr", 0, 1'b1, 1'b1);
      drv_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      tick();
      exp_a("ovfclr", 0, 1'b0, 1'b0);

      // Compare match at 7, then an unreachable compare value.
      drv_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
      ifa.cmp_i = 8'd7;
      #1;
      chk("match_at0", 32'(ifa.match_o), 32'd0);
      drv_a(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("match7.dat", 32'(ifa.dat_o), 32'(i % 10));
         chk("match7", 32'(ifa.match_o), 32'(i == 7));
      end
      ifa.cmp_i = 8'd12;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("match12", 32'(ifa.match_o), 32'd0);
      end
      drv_a(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);

      // Prescaler of 3: stepping, enable gaps and load restarting the interval.
      ifb.dat_i = 8'd50;
      for (int i = 0; i < 16; i++) begin
         ifb.en_i = b_en[i];
         ifb.we_i = b_we[i];
         tick();
         chk("presc.dat", 32'(ifb.dat_o), 32'(b_exp[i]));
         chk("presc.tc", 32'(ifb.tc_o), 32'd0);
      end
      ifb.en_i = 1'b0;
      ifb.we_i = 1'b0;

      // Async reset while instance C shows a wrapped 6 with tc high.
      ifc.en_i = 1'b1;
      tick();
      exp_c("c_ps1", 0, 1'b0, 1'b0);
      tick();
      exp_c("c_wrap", 6, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      exp_c("c_async", 0, 1'b0, 1'b0);
      chk("a_async.dat", 32'(ifa.dat_o), 32'd0);
      chk("b_async.dat", 32'(ifb.dat_o), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      exp_c("c_rel1", 0, 1'b0, 1'b0);
      tick();
      exp_c("c_rel2", 6, 1'b1, 1'b1);
      tick();
      exp_c("c_rel3", 6, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/counter_mod.md
Name: counter_mod

Overview:
- Parametrised successor to the basic 8-bit counter: modulo-N up/down counter with synchronous clear, parallel load, enable prescaler, terminal-count pulse, sticky overflow flag and compare match.
- Used as the timing/event-count primitive in project datapaths.
- Single clock domain. Register interface matches the original counter: clr/en/we/dat.

Parameters:
- WIDTH, 8: counter and data width in bits (2..32).
- MAX, 2**WIDTH-1: terminal value; count range is 0..MAX inclusive. Must satisfy 1 <= MAX <= 2**WIDTH-1.
- PRESCALE, 1: number of enabled cycles per count step (1..256). 1 means the counter steps every enabled cycle.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous clear.
- en_i  in  1  count enable.
- we_i  in  1  parallel load strobe.
- dat_i  in  WIDTH  load value.
- up_i  in  1  direction: 1 = up, 0 = down.
- cmp_i  in  WIDTH  compare value.
- ovf_clr_i  in  1  clears the sticky overflow flag.
- dat_o  out  WIDTH  current count (registered).
- tc_o  out  1  one-cycle pulse on wrap.
- ovf_o  out  1  sticky wrap flag.
- match_o  out  1  high when dat_o == cmp_i (combinational compare of the registered count).

Behaviour:
- Reset (rst_i low, asynchronous):
  - dat_o = 0, tc_o = 0, ovf_o = 0, prescaler = 0.
  - State is held while rst_i is low; normal operation resumes on the first rising edge after release.
- Per-edge priority: clr_i > we_i > counting.
  - clr_i: dat_o <= 0; prescaler <= 0; tc_o <= 0. ovf_o is unaffected.
  - we_i (clr_i low): dat_o <= min(dat_i, MAX); prescaler <= 0; tc_o <= 0. A load never sets tc_o or ovf_o.
  - en_i high (no clr_i or we_i):
    - If prescaler == PRESCALE-1: prescaler <= 0 and a step occurs.
    - Otherwise: prescaler increments and there is no step.
  - en_i low: dat_o and prescaler hold; tc_o <= 0.
- Step rules:
  - Up: if dat_o == MAX then dat_o <= 0, else dat_o + 1.
  - Down: if dat_o == 0 then dat_o <= MAX, else dat_o - 1.
  - A wrap (either direction) sets tc_o <= 1 for exactly one cycle, in the same cycle dat_o shows the wrapped value, and sets ovf_o <= 1.
  - A non-wrap step sets tc_o <= 0.
- Latency:
  - dat_o updates one clock after the qualifying edge inputs.
  - tc_o is registered and aligned with the wrapped dat_o.
- ovf_o:
  - Set on wrap; cleared by ovf_clr_i.
  - If a wrap and ovf_clr_i occur in the same cycle, set wins (ovf_o = 1).
- Direction: up_i is sampled on each step edge. A direction change mid-prescale takes effect at the next step; the prescaler is not reset.
- match_o = (dat_o == cmp_i). cmp_i > MAX never matches.
- Arithmetic is unsigned, WIDTH bits. No intermediate value exceeds MAX. A non-power-of-two MAX wraps at MAX, not at 2**WIDTH-1.
- PRESCALE == 1: the prescaler logic degenerates and the counter steps every enabled cycle.
- Reset asserted mid-prescale or mid-pulse immediately zeros all state, including tc_o.

Test Plan:
- Reset release, WIDTH=8, MAX=9, PRESCALE=1, en_i=1, up_i=1 for 12 cycles:
  - dat_o sequence 0,1,...,9,0,1.
  - tc_o high only in the cycle dat_o returns to 0.
  - ovf_o = 1 from that cycle on.
- Down wrap: load dat_i=2, then en_i=1, up_i=0 for 4 cycles:
  - dat_o sequence 2,1,0,9,8.
  - tc_o pulses with the 9.
  - Load of dat_i=200 yields dat_o=9 (clamped) with no tc_o pulse.
- Prescaler, PRESCALE=3, MAX=255, en_i=1:
  - dat_o steps 0→1→2 every 3 cycles.
  - Dropping en_i for 2 cycles mid-interval delays the next step by exactly 2 cycles.
  - we_i restarts the interval.
- Priority: assert clr_i and we_i (dat_i=5) together with en_i=1 → dat_o=0.
  - Next cycle we_i alone with dat_i=5 → dat_o=5.
  - Wrap cycle with ovf_clr_i=1 → ovf_o stays 1; a later ovf_clr_i alone clears it to 0.
- Compare: cmp_i=7, count up from 0 → match_o high only while dat_o=7.
  - cmp_i=12 with MAX=9 → match_o never asserts.
- Async reset: drive rst_i low between clock edges while dat_o=6 and tc_o=1.
  - Outputs go to 0 immediately, without waiting for a clock edge.
  - After release, counting restarts from 0 with a full PRESCALE interval.
